// File: rtl/fft_stage_sequencer.sv
// ---------------------------------------------------------------------------
// fft_stage_sequencer
//
// Top-level control FSM for the 32-point FFT pipeline. A run launches the
// butterfly stages one after another: each stage gets a single start pulse,
// and the sequencer then waits for that stage's finish pulse before it
// launches the next one. After the last stage finishes it pulses fft_done
// and records how many cycles the run took. stage_index tells the
// twiddle/constant banks which stage is active.
//
// Optional feature (compile-time macro FFT_SEQ_TIMEOUT_EN):
//   When defined, a stage that stays in WAIT for TIMEOUT_CYCLES cycles
//   without finishing aborts the run and sets the sticky timeout_err flag.
//   When undefined, WAIT waits forever and timeout_err is tied low.
//
// Parameters:
//   NUM_STAGES      number of sequenced stages (1..8)
//   TIMEOUT_CYCLES  WAIT cycles allowed per stage before an abort
//   CNT_WIDTH       width of the run-length counter
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high reset
//   fft_start     in   run request, only looked at while idle
//   fft_busy      out  high whenever the sequencer is not idle
//   fft_done      out  one-cycle pulse after the last stage finishes
//   stage_start   out  one-hot, one-cycle launch pulse (bit k -> stage k+1)
//   stage_finish  in   finish pulses from the stages
//   stage_index   out  index of the active stage
//   timeout_err   out  sticky abort flag
//   run_cycles    out  length in cycles of the last completed run
// ---------------------------------------------------------------------------
module fft_stage_sequencer #(
    parameter int NUM_STAGES     = 5,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fft_start,
    output logic                  fft_busy,
    output logic                  fft_done,
    output logic [NUM_STAGES-1:0] stage_start,
    input  logic [NUM_STAGES-1:0] stage_finish,
    output logic [2:0]            stage_index,
    output logic                  timeout_err,
    output logic [CNT_WIDTH-1:0]  run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE,
        S_ABORT
    } state_t;

    localparam logic [2:0]           LAST_INDEX = 3'(NUM_STAGES - 1);
    localparam int                   SUM_W      = CNT_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    // Reject configurations the 3-bit stage index or the counters cannot
    // represent, at elaboration time rather than as odd silicon behaviour.
    if (NUM_STAGES < 1 || NUM_STAGES > 8 || TIMEOUT_CYCLES < 1 || CNT_WIDTH < 1)
    begin : g_param_check
        $error("fft_stage_sequencer: unsupported parameter combination");
    end

    // Saturating add used by the run-length counter; one extra bit of
    // headroom catches the overflow instead of letting it wrap.
    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] base,
        input logic [1:0]           amount
    );
        logic [SUM_W-1:0] sum;
        sum = {1'b0, base} + SUM_W'(amount);
        if (sum > {1'b0, CNT_MAX}) begin
            return CNT_MAX;
        end
        return sum[CNT_WIDTH-1:0];
    endfunction

    state_t                 state;
    state_t                 state_next;
    logic [NUM_STAGES-1:0]  stage_select;
    logic                   finish_hit;
    logic                   at_last_stage;
    logic                   start_accept;
    logic                   stage_advance;
    logic                   run_complete;
    logic                   timeout_hit;
    logic [CNT_WIDTH-1:0]   run_cnt;

    // One-hot mask of the active stage. Only that stage's finish bit is
    // allowed to move the FSM; every other finish bit is masked away.
    assign stage_select  = NUM_STAGES'(1) << stage_index;
    assign finish_hit    = |(stage_finish & stage_select);
    assign at_last_stage = (stage_index == LAST_INDEX);
    assign start_accept  = (state == S_IDLE) && fft_start;
    assign stage_advance = (state == S_WAIT) && finish_hit && !at_last_stage;
    assign run_complete  = (state == S_WAIT) && finish_hit && at_last_stage;

`ifdef FFT_SEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt;

    // The wait counter sits at zero outside WAIT, so it is already cleared
    // on the first WAIT cycle of every stage and then counts WAIT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state != S_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // The limit is hit on the WAIT cycle whose count reaches TIMEOUT_CYCLES.
    // A finish in that same cycle wins, so the abort is gated by finish_hit.
    assign timeout_hit = (state == S_WAIT) && !finish_hit &&
                         (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    // Sticky abort flag: set by a timeout, cleared only by the next
    // accepted run request or by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (start_accept) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the outputs decoded from the registered state.
    // Outputs depend only on state and stage_index, both registers, so no
    // input ever reaches an output combinationally.
    always_comb begin
        state_next  = state;
        fft_busy    = (state != S_IDLE);
        fft_done    = 1'b0;
        stage_start = '0;
        unique case (state)
            S_IDLE: begin
                if (fft_start) begin
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                stage_start = stage_select;
                state_next  = S_WAIT;
            end
            S_WAIT: begin
                if (run_complete) begin
                    state_next = S_DONE;
                end else if (stage_advance) begin
                    state_next = S_LAUNCH;
                end else if (timeout_hit) begin
                    state_next = S_ABORT;
                end
            end
            S_DONE: begin
                fft_done   = 1'b1;
                state_next = S_IDLE;
            end
            S_ABORT: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Stage index: restarts at zero on an accepted request, steps when the
    // active stage finishes, and otherwise holds so the banks keep pointing
    // at the last stage while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_index <= '0;
        end else if (start_accept) begin
            stage_index <= '0;
        end else if (stage_advance) begin
            stage_index <= stage_index + 3'd1;
        end
    end

    // Run-length counter: holds the number of non-idle cycles before the
    // current one. It restarts on an accepted request and saturates instead
    // of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt <= '0;
        end else if (start_accept) begin
            run_cnt <= '0;
        end else if (state != S_IDLE) begin
            run_cnt <= sat_add(run_cnt, 2'd1);
        end
    end

    // Completed-run length. On the edge into DONE, run_cnt still excludes
    // both the current (last WAIT) cycle and the DONE cycle, hence +2.
    // Aborted runs leave the previous value in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cycles <= '0;
        end else if (run_complete) begin
            run_cycles <= sat_add(run_cnt, 2'd2);
        end
    end

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Top-level control FSM for the 32-point FFT pipeline. It launches the five butterfly stages in order over their start/finish handshakes: one start pulse per stage, then it waits for that stage's finish before launching the next. It signals run completion and reports run length, and it holds the stage index that selects twiddle/constant banks. It sits between the system control interface and the FFT_Stage1..5 instances.

## Interface
Parameters:
- NUM_STAGES, 5, number of sequenced stages (max 8).
- TIMEOUT_CYCLES, 15, maximum cycles a stage may stay in WAIT before the run is aborted.
- CNT_WIDTH, 8, width of the run-length counter.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- fft_start  in  1  run request; sampled only in IDLE.
- fft_busy  out  1  high in every state except IDLE.
- fft_done  out  1  one-cycle pulse when the last stage finishes normally.
- stage_start  out  NUM_STAGES  one-hot, one-cycle launch pulse; bit k drives stage k+1's start.
- stage_finish  in  NUM_STAGES  finish pulse from each stage.
- stage_index  out  3  index of the currently active stage, 0..NUM_STAGES-1.
- timeout_err  out  1  sticky abort flag.
- run_cycles  out  CNT_WIDTH  length of the last completed run.

## Operation
- States:
  - IDLE: waits for fft_start.
  - LAUNCH: drives stage_start[stage_index] high for exactly this one cycle.
  - WAIT: waits for stage_finish[stage_index].
  - DONE: asserts fft_done for one cycle.
  - ABORT: one cycle, no fft_done.
- Transitions:
  - IDLE & fft_start → LAUNCH. On this edge: stage_index ← 0, run counter ← 0, timeout_err ← 0.
  - LAUNCH → WAIT unconditionally. A stage_finish in the LAUNCH cycle is ignored.
  - WAIT & stage_finish[stage_index]: if stage_index < NUM_STAGES-1 → LAUNCH with stage_index+1; otherwise → DONE.
  - DONE → IDLE. ABORT → IDLE.
- Ignored inputs:
  - finish bits other than stage_finish[stage_index];
  - fft_start in any state other than IDLE (it is not queued).
- Run counter:
  - increments every cycle the block is not in IDLE;
  - saturates at 2^CNT_WIDTH-1, no wrap;
  - is copied to run_cycles on the cycle the FSM enters DONE, counting the DONE cycle;
  - run_cycles is not updated on ABORT.
- stage_index holds its value in DONE/ABORT/IDLE until the next accepted start.
- A reset asserted mid-run forces IDLE on the next edge and drops any stage_start pulse. Stages are reset by the same signal.

## Timing
- Reset values:
  - state IDLE;
  - fft_busy 0, fft_done 0, stage_start 0;
  - stage_index 0, timeout_err 0, run_cycles 0.
- All outputs are registered or decoded from registered state; there is no combinational input→output path.
- fft_start sampled at edge of cycle 0 → stage_start[0] and fft_busy high in cycle 1.
- stage_finish[k] in cycle t → stage_start[k+1] in cycle t+1.
- Last finish in cycle t → fft_done and fft_busy in t+1; fft_busy low in t+2.
- The earliest a new fft_start is accepted is cycle t+2.
- Minimum run length: NUM_STAGES·2 + 1 cycles, reached when each finish arrives in the first WAIT cycle.

## Configuration
- FFT_SEQ_TIMEOUT_EN defined:
  - a wait counter is cleared on entry to WAIT and increments each WAIT cycle;
  - if it reaches TIMEOUT_CYCLES without the expected finish, the FSM goes to ABORT and timeout_err ← 1;
  - timeout_err stays 1 until the next accepted fft_start or reset;
  - a finish arriving in the same cycle the count reaches the limit takes priority (normal progress).
- FFT_SEQ_TIMEOUT_EN undefined:
  - no wait counter;
  - WAIT waits indefinitely;
  - timeout_err is tied to 0.

## Test plan
- Nominal run: stub stages that finish 4 cycles after start; fft_start in cycle 0.
  - Required: stage_start[k] in cycle 1+5k; fft_done in cycle 26; fft_busy in cycles 1..26; run_cycles=26.
- Zero-wait stages (finish in the first WAIT cycle).
  - Required: fft_done in cycle 11; run_cycles=11.
- Spurious inputs: pulse stage_finish[3] while waiting on stage 1, and fft_start mid-run.
  - Required: no stage advance, no second run; timing identical to the nominal run.
- Reset in cycle 8 of a nominal run.
  - Required: cycle 9 is IDLE with all outputs at reset values.
  - A fresh fft_start afterwards completes with run_cycles=26.
- With FFT_SEQ_TIMEOUT_EN, stage 2 never finishes.
  - Required: ABORT 15 cycles after entering WAIT; timeout_err=1; no fft_done; run_cycles unchanged.
  - The next fft_start clears timeout_err.
- run_cycles saturation: CNT_WIDTH=4 with nominal stubs.
  - Required: run_cycles=15.
